hex_event_counter: RTL and testbench
====================================

HEX_EVENT_COUNTER -- requirements
Module: hex_event_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 2, meaning the number of hex digits; the counter width is CW = 4*DIGITS.
REQ-002 SHALL have parameter DEB_CYC, default 500000, meaning the number of consecutive stable cycles required to accept a key level (minimum 2).
REQ-003 SHALL have parameter SAT, default 0, meaning 0 = wrap-around arithmetic and 1 = saturating arithmetic.
REQ-004 SHALL have parameter BLANK, default 0, meaning 1 = leading-zero blanking is enabled.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rstn_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port key_i, input, 1 bit: asynchronous, active-low pushbutton (0 = pressed).
REQ-008 SHALL have port dir_i, input, 1 bit: 0 = count up, 1 = count down.
REQ-009 SHALL have port step_i, input, 8 bits: unsigned increment, zero-extended or truncated to CW.
REQ-010 SHALL have port clr_i, input, 1 bit: synchronous clear of the counter.
REQ-011 SHALL have port count_o, output, CW bits: the current counter value.
REQ-012 SHALL have port hex_o, output, 7*DIGITS bits: active-low segments gfedcba; digit k occupies bits [7k+6:7k].
REQ-013 SHALL have port ovf_o, output, 1 bit: one-cycle pulse on wrap or saturation.

Function
REQ-014 SHALL pass key_i through a 2-flop synchronizer before any other use.
REQ-015 SHALL implement a debounce FSM with these states: IDLE (released), PRESS_CHK, HELD, REL_CHK.
REQ-016 IDLE -> PRESS_CHK on a synchronized 0; the debounce counter loads 0.
REQ-017 PRESS_CHK: a synchronized 1 SHALL return the FSM to IDLE; on reaching DEB_CYC-1 consecutive 0 samples, the FSM SHALL go to HELD and assert the internal event for exactly one cycle.
REQ-018 HELD -> REL_CHK on a synchronized 1; REL_CHK -> HELD on a 0; REL_CHK -> IDLE after DEB_CYC-1 consecutive 1 samples.
REQ-019 Holding the key SHALL produce exactly one event; bounces shorter than DEB_CYC cycles SHALL produce none.
REQ-020 On an event, count_o SHALL update at the next clock edge to count+step for dir_i=0, or count-step for dir_i=1, using the dir_i/step_i values sampled in the event cycle.
REQ-021 With SAT=0, results SHALL be taken mod 2^CW, and ovf_o SHALL pulse when a carry or borrow occurs.
REQ-022 With SAT=1, results SHALL clamp to 2^CW-1 (up) or 0 (down), and ovf_o SHALL pulse when clamping changes the result; an event while already at the limit SHALL still pulse ovf_o.
REQ-023 step_i=0 on an event SHALL leave count_o unchanged, with no ovf_o.
REQ-024 clr_i=1 SHALL set count_o to 0 at the next edge, overriding a simultaneous event; ovf_o SHALL be 0 in that cycle.
REQ-025 hex_o SHALL be registered, lagging count_o by exactly one cycle.
REQ-026 Digit encoding (active-low gfedcba), 0-F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-027 With BLANK=1, every digit above the most significant nonzero nibble SHALL output 1111111; digit 0 SHALL never be blanked.
REQ-028 The debounce counter SHALL be sized ceil(log2(DEB_CYC)) bits and SHALL not wrap within a check state.

Reset
REQ-029 rstn_i=0 SHALL immediately force: FSM = IDLE, synchronizer flops = 1, debounce counter = 0, count_o = 0, ovf_o = 0, hex_o = all digits "0" (1000000), or, with BLANK=1, digit 0 = 1000000 and the other digits = 1111111.
REQ-030 A reset asserted while in HELD SHALL NOT generate an event after release of reset while key_i is still held; the FSM SHALL pass through PRESS_CHK again.

Verification
REQ-031 DIGITS=2, DEB_CYC=4: hold key_i=0 for 20 cycles with step=1, dir=0 -> count_o 00->01 exactly once; hex_o = 1000000_1111001 one cycle later.
REQ-032 Pulse key_i low for 2 cycles, repeated 5 times -> count_o unchanged and ovf_o never asserted.
REQ-033 SAT=0, count=FE, step=3, up -> count=01 and one ovf_o pulse; count=01, step=2, down -> count=FF and one ovf_o pulse.
REQ-034 SAT=1, count=FE, step=3, up -> count=FF and ovf_o pulse; a further press -> count stays FF, ovf_o pulses again.
REQ-035 Assert clr_i in the same cycle as an event at count=37 -> count=00, ovf_o=0.
REQ-036 BLANK=1, DIGITS=3, count=005 -> hex_o = 1111111_1111111_0010010; then rstn_i low mid-press -> all outputs at reset values immediately.

Source files
------------

// File: rtl/hex_event_counter.sv
// Debounced pushbutton event counter with configurable step/direction and
// registered 7-segment (active-low gfedcba) hex display output.
//
// state     | meaning
// IDLE      | key released and stable
// PRESS_CHK | key seen low, counting consecutive low samples
// HELD      | press accepted, one event already issued
// REL_CHK   | key seen high, counting consecutive high samples
module hex_event_counter #(
    parameter int DIGITS  = 2,
    parameter int DEB_CYC = 500000,
    parameter int SAT     = 0,
    parameter int BLANK   = 0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  key_i,
    input  logic                  dir_i,
    input  logic [7:0]            step_i,
    input  logic                  clr_i,
    output logic [4*DIGITS-1:0]   count_o,
    output logic [7*DIGITS-1:0]   hex_o,
    output logic                  ovf_o
);

    localparam int CW = 4 * DIGITS;
    localparam int DW = $clog2(DEB_CYC);
    // The sample that leaves IDLE counts as the first, so the terminal count is DEB_CYC-2.
    localparam logic [DW-1:0] DEB_TC = DW'(DEB_CYC - 2);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_deb_cnt;
    logic [DW-1:0]   w_deb_cnt_nxt;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_event;

    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic [7*DIGITS-1:0] r_hex;

    logic [CW-1:0]   w_step;
    logic [CW:0]     w_sum;
    logic [CW:0]     w_diff;
    logic            w_carry;
    logic [CW-1:0]   w_raw;
    logic [CW-1:0]   w_res;

    function automatic logic [6:0] f_seg(input logic [3:0] n);
        case (n)
            4'h0:    f_seg = 7'b1000000;
            4'h1:    f_seg = 7'b1111001;
            4'h2:    f_seg = 7'b0100100;
            4'h3:    f_seg = 7'b0110000;
            4'h4:    f_seg = 7'b0011001;
            4'h5:    f_seg = 7'b0010010;
            4'h6:    f_seg = 7'b0000010;
            4'h7:    f_seg = 7'b1111000;
            4'h8:    f_seg = 7'b0000000;
            4'h9:    f_seg = 7'b0010000;
            4'hA:    f_seg = 7'b0001000;
            4'hB:    f_seg = 7'b0000011;
            4'hC:    f_seg = 7'b1000110;
            4'hD:    f_seg = 7'b0100001;
            4'hE:    f_seg = 7'b0000110;
            default: f_seg = 7'b0001110;
        endcase
    endfunction

    // Scan from the top digit; blanking stops at the first nonzero nibble.
    function automatic logic [7*DIGITS-1:0] f_hex(input logic [CW-1:0] v);
        logic [7*DIGITS-1:0] hex;
        logic                seen;
        logic [3:0]          nib;
        hex  = '1;
        seen = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib = v[4*k +: 4];
            if (nib != 4'h0 || k == 0) seen = 1'b1;
            hex[7*k +: 7] = (BLANK != 0 && !seen) ? 7'b1111111 : f_seg(nib);
        end
        return hex;
    endfunction

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_i;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= IDLE;
            r_deb_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_deb_cnt <= w_deb_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_deb_cnt_nxt = r_deb_cnt;
        w_event       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_sync2) begin
                    w_state_nxt   = PRESS_CHK;
                    w_deb_cnt_nxt = '0;
                end
            end
            PRESS_CHK: begin
                if (r_sync2) begin
                    w_state_nxt = IDLE;
                end else if (r_deb_cnt == DEB_TC) begin
                    w_state_nxt = HELD;
                    w_event     = 1'b1;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                end
            end
            HELD: begin
                if (r_sync2) begin
                    w_state_nxt   = REL_CHK;
                    w_deb_cnt_nxt = '0;
                end
            end
            REL_CHK: begin
                if (!r_sync2) begin
                    w_state_nxt = HELD;
                end else if (r_deb_cnt == DEB_TC) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_step  = CW'(step_i);
    assign w_sum   = {1'b0, r_count} + {1'b0, w_step};
    assign w_diff  = {1'b0, r_count} - {1'b0, w_step};
    assign w_carry = dir_i ? w_diff[CW] : w_sum[CW];
    assign w_raw   = dir_i ? w_diff[CW-1:0] : w_sum[CW-1:0];
    assign w_res   = (SAT != 0 && w_carry) ? (dir_i ? '0 : '1) : w_raw;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clr_i) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_event) begin
            r_count <= w_res;
            r_ovf   <= w_carry;
        end else begin
            r_ovf   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_hex <= f_hex('0);
        else         r_hex <= f_hex(r_count);
    end

    assign count_o = r_count;
    assign hex_o   = r_hex;
    assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_hex_event_counter.sv
// Directed bench: wrap, saturating and blanking variants of hex_event_counter
// exercised side by side on a short debounce window.
module tb_hex_event_counter;

    logic        clk;
    logic        rstn;
    logic [2:0]  key;
    logic        dir;
    logic [7:0]  step;
    logic        clr;

    logic [7:0]  cnt0, cnt1;
    logic [11:0] cnt2;
    logic [13:0] hex0, hex1;
    logic [20:0] hex2;
    logic        ovf0, ovf1, ovf2;

    int n_checks;
    int n_fail;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SB = 7'b1111111;

    hex_event_counter #(.DIGITS(2), .DEB_CYC(4), .SAT(0), .BLANK(0)) u0 (
        .clk_i(clk), .rstn_i(rstn), .key_i(key[0]), .dir_i(dir), .step_i(step),
        .clr_i(clr), .count_o(cnt0), .hex_o(hex0), .ovf_o(ovf0));

    hex_event_counter #(.DIGITS(2), .DEB_CYC(4), .SAT(1), .BLANK(0)) u1 (
        .clk_i(clk), .rstn_i(rstn), .key_i(key[1]), .dir_i(dir), .step_i(step),
        .clr_i(clr), .count_o(cnt1), .hex_o(hex1), .ovf_o(ovf1));

    hex_event_counter #(.DIGITS(3), .DEB_CYC(4), .SAT(0), .BLANK(1)) u2 (
        .clk_i(clk), .rstn_i(rstn), .key_i(key[2]), .dir_i(dir), .step_i(step),
        .clr_i(clr), .count_o(cnt2), .hex_o(hex2), .ovf_o(ovf2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ovf_of(input int idx);
        case (idx)
            0:       return ovf0;
            1:       return ovf1;
            default: return ovf2;
        endcase
    endfunction

    // One clean press of 'hold' cycles followed by a full release; counts ovf pulses.
    task automatic press(input int idx, input int hold, output int n_ovf);
        n_ovf = 0;
        key[idx] = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if (ovf_of(idx)) n_ovf++;
        end
        key[idx] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ovf_of(idx)) n_ovf++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        key  = 3'b111;
        dir  = 1'b0;
        step = 8'h00;
        clr  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cnt0 !== 8'h00) begin n_fail++; $display("FAIL reset_cnt0: got %h expected 00", cnt0); end
        n_checks++;
        if (hex0 !== {S0, S0}) begin n_fail++; $display("FAIL reset_hex0: got %b expected %b", hex0, {S0, S0}); end
        n_checks++;
        if (ovf0 !== 1'b0 || ovf1 !== 1'b0 || ovf2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_ovf: got %b%b%b expected 000", ovf0, ovf1, ovf2);
        end
        n_checks++;
        if (cnt2 !== 12'h000) begin n_fail++; $display("FAIL reset_cnt2: got %h expected 000", cnt2); end
        n_checks++;
        if (hex2 !== {SB, SB, S0}) begin n_fail++; $display("FAIL reset_hex2_blank: got %b expected %b", hex2, {SB, SB, S0}); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_event();
        int          changes;
        int          first;
        logic [7:0]  prev;
        logic [13:0] hex_at;
        logic [13:0] hex_next;
        changes  = 0;
        first    = -1;
        hex_at   = '0;
        hex_next = '0;
        step     = 8'd1;
        dir      = 1'b0;
        prev     = cnt0;
        key[0]   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (first >= 0 && i == first + 1) hex_next = hex0;
            if (cnt0 !== prev) begin
                changes++;
                if (first < 0) begin
                    first  = i;
                    hex_at = hex0;
                end
            end
            prev = cnt0;
        end
        key[0] = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (changes != 1) begin n_fail++; $display("FAIL hold_one_event: got %0d count changes expected 1", changes); end
        n_checks++;
        if (cnt0 !== 8'h01) begin n_fail++; $display("FAIL hold_count: got %h expected 01", cnt0); end
        n_checks++;
        if (hex_at !== {S0, S0}) begin n_fail++; $display("FAIL hex_lag: got %b expected %b", hex_at, {S0, S0}); end
        n_checks++;
        if (hex_next !== {S0, S1}) begin n_fail++; $display("FAIL hex_01: got %b expected %b", hex_next, {S0, S1}); end
    endtask

    task automatic test_bounce();
        int n_ovf;
        n_ovf = 0;
        repeat (5) begin
            key[0] = 1'b0;
            repeat (2) begin @(negedge clk); if (ovf0) n_ovf++; end
            key[0] = 1'b1;
            repeat (6) begin @(negedge clk); if (ovf0) n_ovf++; end
        end
        n_checks++;
        if (cnt0 !== 8'h01) begin n_fail++; $display("FAIL bounce_count: got %h expected 01", cnt0); end
        n_checks++;
        if (n_ovf != 0) begin n_fail++; $display("FAIL bounce_ovf: got %0d pulses expected 0", n_ovf); end
    endtask

    task automatic test_wrap();
        int n;
        dir = 1'b0; step = 8'hFD;
        press(0, 12, n);
        n_checks++;
        if (cnt0 !== 8'hFE || n != 0) begin n_fail++; $display("FAIL wrap_setup: got %h/%0d expected FE/0", cnt0, n); end
        step = 8'h03;
        press(0, 12, n);
        n_checks++;
        if (cnt0 !== 8'h01 || n != 1) begin n_fail++; $display("FAIL wrap_up: got %h/%0d expected 01/1", cnt0, n); end
        dir = 1'b1; step = 8'h02;
        press(0, 12, n);
        n_checks++;
        if (cnt0 !== 8'hFF || n != 1) begin n_fail++; $display("FAIL wrap_down: got %h/%0d expected FF/1", cnt0, n); end
        step = 8'h00;
        press(0, 12, n);
        n_checks++;
        if (cnt0 !== 8'hFF || n != 0) begin n_fail++; $display("FAIL step_zero: got %h/%0d expected FF/0", cnt0, n); end
        dir = 1'b0;
    endtask

    task automatic test_sat();
        int n;
        dir = 1'b0; step = 8'hFE;
        press(1, 12, n);
        n_checks++;
        if (cnt1 !== 8'hFE || n != 0) begin n_fail++; $display("FAIL sat_setup: got %h/%0d expected FE/0", cnt1, n); end
        step = 8'h03;
        press(1, 12, n);
        n_checks++;
        if (cnt1 !== 8'hFF || n != 1) begin n_fail++; $display("FAIL sat_up: got %h/%0d expected FF/1", cnt1, n); end
        press(1, 12, n);
        n_checks++;
        if (cnt1 !== 8'hFF || n != 1) begin n_fail++; $display("FAIL sat_at_limit: got %h/%0d expected FF/1", cnt1, n); end
        n_checks++;
        if (hex1 !== {SF, SF}) begin n_fail++; $display("FAIL sat_hex_ff: got %b expected %b", hex1, {SF, SF}); end
        dir = 1'b1; step = 8'hFF;
        press(1, 12, n);
        n_checks++;
        if (cnt1 !== 8'h00 || n != 0) begin n_fail++; $display("FAIL sat_down_exact: got %h/%0d expected 00/0", cnt1, n); end
        step = 8'h01;
        press(1, 12, n);
        n_checks++;
        if (cnt1 !== 8'h00 || n != 1) begin n_fail++; $display("FAIL sat_down_clamp: got %h/%0d expected 00/1", cnt1, n); end
        dir = 1'b0;
    endtask

    task automatic test_clear();
        int n;
        dir = 1'b0; step = 8'h38;
        press(0, 12, n);
        n_checks++;
        if (cnt0 !== 8'h37 || n != 1) begin n_fail++; $display("FAIL clr_setup: got %h/%0d expected 37/1", cnt0, n); end
        // Without the clear this event would wrap to 36 and pulse ovf.
        step = 8'hFF;
        key[0] = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (cnt0 !== 8'h37) begin n_fail++; $display("FAIL clr_pre_event: got %h expected 37", cnt0); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++;
        if (cnt0 !== 8'h00 || ovf0 !== 1'b0) begin
            n_fail++; $display("FAIL clr_vs_event: got %h/%b expected 00/0", cnt0, ovf0);
        end
        @(negedge clk);
        n_checks++;
        if (cnt0 !== 8'h00 || ovf0 !== 1'b0) begin
            n_fail++; $display("FAIL clr_after: got %h/%b expected 00/0", cnt0, ovf0);
        end
        key[0] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_blank();
        int n;
        dir = 1'b0; step = 8'h05;
        press(2, 12, n);
        n_checks++;
        if (cnt2 !== 12'h005) begin n_fail++; $display("FAIL blank_count: got %h expected 005", cnt2); end
        n_checks++;
        if (hex2 !== {SB, SB, S5}) begin n_fail++; $display("FAIL blank_005: got %b expected %b", hex2, {SB, SB, S5}); end
        step = 8'hFF;
        press(2, 12, n);
        n_checks++;
        if (hex2 !== {S1, S0, S4}) begin n_fail++; $display("FAIL blank_104: got %b expected %b", hex2, {S1, S0, S4}); end
    endtask

    task automatic test_reset_mid_press();
        int bad;
        key[2] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (cnt2 !== 12'h000 || ovf2 !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_cnt2: got %h/%b expected 000/0", cnt2, ovf2);
        end
        n_checks++;
        if (hex2 !== {SB, SB, S0}) begin n_fail++; $display("FAIL async_rst_hex2: got %b expected %b", hex2, {SB, SB, S0}); end
        n_checks++;
        if (cnt0 !== 8'h00 || hex0 !== {S0, S0}) begin
            n_fail++; $display("FAIL async_rst_u0: got %h/%b expected 00/%b", cnt0, hex0, {S0, S0});
        end
        @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        repeat (4) begin @(negedge clk); if (cnt2 !== 12'h000) bad++; end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL rst_release_held: got %0d bad cycles expected 0", bad); end
        // Let the still-held key debounce into HELD, then reset from HELD.
        repeat (8) @(negedge clk);
        #2 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        repeat (4) begin @(negedge clk); if (cnt2 !== 12'h000 || ovf2 !== 1'b0) bad++; end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL rst_from_held: got %0d bad cycles expected 0", bad); end
        key[2] = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_event();
        test_bounce();
        test_wrap();
        test_sat();
        test_clear();
        test_blank();
        test_reset_mid_press();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
